// File: rtl/scr1_tcm_portb_arb.sv
// ----------------------------------------------------------------------------
// scr1_tcm_portb_arb
// Arbitrates TCM port B between the core dmem path and the accelerator master.
// The core has fixed priority. A starvation guard lets the accelerator win one
// conflict after it has waited STARVE_MAX cycles. An accelerator lock holds the
// port for atomic read-modify-write sequences, and LOCK_MAX bounds how long it
// can be held.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   core_req/wr/addr/wdata/be        core access request
//   core_ack, core_rvalid            core issued this cycle / read data valid
//   acc_req/wr/lock/addr/wdata/be    accelerator access request (+ lock hold)
//   acc_ack, acc_rvalid              accel issued this cycle / read data valid
//   mem_ren/wen/addr/wdata/be        port B memory pins
//   acc_owner                        high while the accelerator holds the lock
//
// Read data comes straight from the memory's port B output one cycle after
// the access is issued. It is qualified by core_rvalid or acc_rvalid and is
// not registered here.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// ARB    | normal arbitration: core priority plus the starvation guard
// LOCKED | accelerator holds the port; core is stalled until release/timeout
// ----------------------------------------------------------------------------
module scr1_tcm_portb_arb #(
  parameter int AWIDTH     = 14,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_wr,
  input  logic [AWIDTH-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [3:0]        core_be,
  output logic              core_ack,
  output logic              core_rvalid,
  input  logic              acc_req,
  input  logic              acc_wr,
  input  logic              acc_lock,
  input  logic [AWIDTH-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  input  logic [3:0]        acc_be,
  output logic              acc_ack,
  output logic              acc_rvalid,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              acc_owner
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
  localparam logic [7:0] LOCK_LAST  = 8'(LOCK_MAX - 1);

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] starve_cnt;
  logic [7:0] lock_cnt;
  logic       core_gnt;
  logic       acc_gnt;
  logic       lock_timeout;

  assign lock_timeout = (state == LOCKED) && (lock_cnt == LOCK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant and next state. The starvation override only matters in ARB:
  // in LOCKED the core is never granted, so the accelerator cannot starve.
  always_comb begin
    core_gnt  = 1'b0;
    acc_gnt   = 1'b0;
    state_nxt = state;
    case (state)
      ARB: begin
        if (core_req && !(acc_req && (starve_cnt == STARVE_LIM))) begin
          core_gnt = 1'b1;
        end else if (acc_req) begin
          acc_gnt = 1'b1;
        end
        if (acc_gnt && acc_lock) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        acc_gnt = acc_req;
        // Timeout releases the port even if this cycle's access asks to keep
        // the lock; the access itself is still issued.
        if (lock_timeout || (acc_gnt && !acc_lock) || (!acc_req && !acc_lock)) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  assign core_ack  = core_gnt;
  assign acc_ack   = acc_gnt;
  assign acc_owner = (state == LOCKED);

  always_comb begin
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (core_gnt) begin
      mem_ren   = ~core_wr;
      mem_wen   = core_wr;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_be    = core_be;
    end else if (acc_gnt) begin
      mem_ren   = ~acc_wr;
      mem_wen   = acc_wr;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
      mem_be    = acc_be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (acc_gnt) begin
      starve_cnt <= '0;
    end else if (acc_req && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Holding the count at zero outside LOCKED gives the clear-on-entry behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if (state == LOCKED) begin
      lock_cnt <= lock_cnt + 8'd1;
    end else begin
      lock_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rvalid <= 1'b0;
      acc_rvalid  <= 1'b0;
    end else begin
      core_rvalid <= core_gnt & ~core_wr;
      acc_rvalid  <= acc_gnt & ~acc_wr;
    end
  end

endmodule
